// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Provides the address/instruction word types, the ROM enable levels,
// the default reset PC and the {pc,inst} entry carried by the prefetch queue.
package inst_fetch_ctrl_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_t      ZERO_WORD        = '0;
  localparam logic       CHIP_ENABLE      = 1'b1;
  localparam logic       CHIP_DISABLE     = 1'b0;
  localparam logic       RST_ENABLE       = 1'b1;
  localparam inst_addr_t RESET_PC_DEFAULT = 32'h0000_0000;

  // One prefetch queue entry: the PC it was fetched from plus the ROM word.
  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } qentry_t;

  // Sequential PC step; wraps modulo 2^32 by construction.
  function automatic inst_addr_t pc_incr(input inst_addr_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Bundle of the fetch controller's ROM bus, redirect input and decode handshake.
// master: the fetch controller (drives rom_ce/rom_addr and the if_* head outputs).
// slave : the environment (ROM data, redirect request, decode if_ready).
interface inst_fetch_ctrl_if;
  import inst_fetch_ctrl_pkg::*;

  logic       rom_ce;
  inst_addr_t rom_addr;
  inst_t      rom_inst;
  logic       redirect;
  inst_addr_t redirect_pc;
  logic       if_valid;
  logic       if_ready;
  inst_t      if_inst;
  inst_addr_t if_pc;
  logic       if_misalign;

  modport master (
    output rom_ce, rom_addr, if_valid, if_inst, if_pc, if_misalign,
    input  rom_inst, redirect, redirect_pc, if_ready
  );

  modport slave (
    input  rom_ce, rom_addr, if_valid, if_inst, if_pc, if_misalign,
    output rom_inst, redirect, redirect_pc, if_ready
  );

endinterface

// File: rtl/inst_fetch_ctrl_fetch_queue.sv
// Prefetch FIFO of {pc,inst} entries; push/pop/flush, head visible combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push accepted when not full or when popping the same cycle; flush wins over both.
// Ports: clk, rst (async, active-high), push, pop, flush, din -> full, empty, head.
module fetch_queue
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  logic    flush,
  input  qentry_t din,
  output logic    full,
  output logic    empty,
  output qentry_t head
);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  qentry_t               mem_q [DEPTH];
  qentry_t               mem_d [DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign full  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A full queue still takes a push when the head leaves in the same cycle:
  // the write lands in the slot being vacated.
  assign do_pop  = pop & ~flush & ~empty;
  assign do_push = push & ~flush & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (DEPTH_LOG2)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (DEPTH_LOG2)'(1);
      count_d = count_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count/pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives ROM ce/addr, buffers {pc,inst} and presents them to decode.
// Latency: fetched in cycle N -> on if_* in cycle N+1; redirect target on if_* two cycles after redirect.
// Backpressure: fetch stalls (rom_ce=0, pc holds) while the queue is full and decode is not taking the head.
// Ports: clk, rst (async, active-high), bus (inst_fetch_ctrl_if.master: ROM bus, redirect, decode handshake).
// Optional: define FETCH_MISALIGN_CHK_EN to trap unaligned redirect targets (sticky, reported on if_misalign).
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter inst_addr_t RESET_PC    = RESET_PC_DEFAULT,
  parameter int         QDEPTH      = 4,
  parameter int         QDEPTH_LOG2 = 2
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_ctrl_if.master bus
);

  inst_addr_t pc_q, pc_d;
  logic       fetch_en_q, fetch_en_d;
  logic       q_full;
  logic       q_empty;
  qentry_t    q_head;
  qentry_t    q_din;
  logic       head_vld;
  logic       pop;
  logic       issue;
  logic       fetch_block;

  assign head_vld = ~q_empty;
  assign pop      = head_vld & bus.if_ready;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;

  assign fetch_block = misalign_q;

  always_comb begin
    misalign_d = misalign_q;
    if (bus.redirect) misalign_d = |bus.redirect_pc[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  // Reported only once everything fetched before the bad redirect is gone.
  assign bus.if_misalign = misalign_q & q_empty;
`else
  assign fetch_block     = 1'b0;
  assign bus.if_misalign = 1'b0;
`endif

  // Redirect suppresses the fetch of its own cycle: the queue is being flushed.
  assign issue = fetch_en_q & ~bus.redirect & ~fetch_block & (~q_full | pop);

  always_comb begin
    pc_d       = pc_q;
    fetch_en_d = 1'b1;
    if (bus.redirect) begin
`ifdef FETCH_MISALIGN_CHK_EN
      pc_d = bus.redirect_pc;
`else
      pc_d = bus.redirect_pc & ~32'h3;
`endif
    end else if (issue) begin
      pc_d = pc_incr(pc_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      fetch_en_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      fetch_en_q <= fetch_en_d;
    end
  end

  assign q_din = '{pc: pc_q, inst: bus.rom_inst};

  fetch_queue #(
    .DEPTH      (QDEPTH),
    .DEPTH_LOG2 (QDEPTH_LOG2)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .pop   (pop),
    .flush (bus.redirect),
    .din   (q_din),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

  assign bus.rom_ce   = issue ? CHIP_ENABLE : CHIP_DISABLE;
  assign bus.rom_addr = pc_q;
  assign bus.if_valid = head_vld;
  assign bus.if_inst  = head_vld ? q_head.inst : ZERO_WORD;
  assign bus.if_pc    = head_vld ? q_head.pc   : '0;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl; ROM model returns {8'hE0, addr[23:0]}.
// Cycle k means the interval after the k-th rising edge following reset release.
module tb_inst_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  inst_fetch_ctrl_if bus ();

  assign bus.rom_inst = {8'hE0, bus.rom_addr[23:0]};

  inst_fetch_ctrl #(
    .RESET_PC    (32'h0000_0000),
    .QDEPTH      (4),
    .QDEPTH_LOG2 (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench in cycle 0 (just after release, before the first edge).
  task automatic do_reset();
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.if_ready    = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.if_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #2;
    checks++; if (bus.rom_ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %b exp 0", bus.rom_ce); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.if_valid); end
    checks++; if (bus.if_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", bus.if_inst); end
    checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", bus.if_pc); end
    checks++; if (bus.if_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", bus.if_misalign); end
    do_reset();
    bus.if_ready = 1'b1;
    #1;
    checks++; if (bus.rom_ce !== 1'b0) begin errors++; $display("FAIL cycle0_ce got %b exp 0", bus.rom_ce); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    bus.if_ready = 1'b1;
    tick(); #1;
    checks++; if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h0) begin errors++; $display("FAIL stream_c1 got ce=%b addr=%h exp ce=1 addr=0", bus.rom_ce, bus.rom_addr); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL stream_c1_valid got %b exp 0", bus.if_valid); end
    for (int k = 2; k <= 7; k++) begin
      tick(); #1;
      exp_pc = 32'(4 * (k - 2));
      checks++; if (bus.rom_addr !== 32'(4 * (k - 1)) || bus.rom_ce !== 1'b1) begin errors++; $display("FAIL stream_addr c%0d got ce=%b addr=%h exp ce=1 addr=%h", k, bus.rom_ce, bus.rom_addr, 32'(4 * (k - 1))); end
      checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc || bus.if_inst !== {8'hE0, exp_pc[23:0]}) begin errors++; $display("FAIL stream_head c%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h", k, bus.if_valid, bus.if_pc, bus.if_inst, exp_pc, {8'hE0, exp_pc[23:0]}); end
    end
  endtask

  task automatic test_stall_full();
    int issues;
    logic [31:0] exp_pc;
    do_reset();
    issues = 0;
    for (int c = 1; c <= 10; c++) begin
      tick(); #1;
      if (bus.rom_ce === 1'b1) issues++;
    end
    checks++; if (issues != 4) begin errors++; $display("FAIL stall_issues got %0d exp 4", issues); end
    checks++; if (bus.rom_ce !== 1'b0 || bus.rom_addr !== 32'h10) begin errors++; $display("FAIL stall_hold got ce=%b addr=%h exp ce=0 addr=10", bus.rom_ce, bus.rom_addr); end
    checks++; if (dut.u_queue.count_q !== 3'd4) begin errors++; $display("FAIL stall_count got %0d exp 4", dut.u_queue.count_q); end
    bus.if_ready = 1'b1;
    #1;
    checks++; if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h10 || bus.if_pc !== 32'h0) begin errors++; $display("FAIL fullpop_issue got ce=%b addr=%h pc=%h exp ce=1 addr=10 pc=0", bus.rom_ce, bus.rom_addr, bus.if_pc); end
    tick(); #1;
    checks++; if (dut.u_queue.count_q !== 3'd4) begin errors++; $display("FAIL fullpop_count got %0d exp 4", dut.u_queue.count_q); end
    exp_pc = 32'h4;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc) begin errors++; $display("FAIL drain_order i%0d got v=%b pc=%h exp v=1 pc=%h", i, bus.if_valid, bus.if_pc, exp_pc); end
      exp_pc = exp_pc + 32'h4;
      tick(); #1;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    tick(); tick(); tick();
    tick();
    checks++; if (dut.u_queue.count_q !== 3'd3) begin errors++; $display("FAIL redir_pre_count got %0d exp 3", dut.u_queue.count_q); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h100; bus.if_ready = 1'b1;
    #1;
    checks++; if (bus.rom_ce !== 1'b0) begin errors++; $display("FAIL redir_ce got %b exp 0", bus.rom_ce); end
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++; if (bus.if_valid !== 1'b0 || bus.rom_addr !== 32'h100 || bus.rom_ce !== 1'b1) begin errors++; $display("FAIL redir_next got v=%b addr=%h ce=%b exp v=0 addr=100 ce=1", bus.if_valid, bus.rom_addr, bus.rom_ce); end
    tick(); #1;
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || bus.if_inst !== 32'hE000_0100) begin errors++; $display("FAIL redir_target got v=%b pc=%h inst=%h exp v=1 pc=100 inst=e0000100", bus.if_valid, bus.if_pc, bus.if_inst); end
    tick(); #1;
    checks++; if (bus.if_pc !== 32'h104) begin errors++; $display("FAIL redir_follow got %h exp 104", bus.if_pc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
    #1;
    checks++; if (bus.rom_ce !== 1'b0) begin errors++; $display("FAIL early_redir_ce got %b exp 0", bus.rom_ce); end
    tick();
    bus.redirect = 1'b0; bus.if_ready = 1'b1;
    #1;
    checks++; if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h40) begin errors++; $display("FAIL early_redir_fetch got ce=%b addr=%h exp ce=1 addr=40", bus.rom_ce, bus.rom_addr); end
    tick(); #1;
    checks++; if (bus.if_pc !== 32'h40) begin errors++; $display("FAIL early_redir_head got %h exp 40", bus.if_pc); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    tick();
    bus.redirect_pc = 32'h300;
    #1;
    checks++; if (bus.if_valid !== 1'b0 || bus.rom_ce !== 1'b0 || bus.rom_addr !== 32'h200) begin errors++; $display("FAIL b2b_mid got v=%b ce=%b addr=%h exp v=0 ce=0 addr=200", bus.if_valid, bus.rom_ce, bus.rom_addr); end
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++; if (bus.rom_addr !== 32'h300 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL b2b_last got addr=%h v=%b exp addr=300 v=0", bus.rom_addr, bus.if_valid); end
    tick(); #1;
    checks++; if (bus.if_pc !== 32'h300 || bus.if_valid !== 1'b1) begin errors++; $display("FAIL b2b_head got pc=%h v=%b exp pc=300 v=1", bus.if_pc, bus.if_valid); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0; bus.if_ready = 1'b1;
    #1;
    checks++; if (bus.rom_addr !== 32'hFFFF_FFFC || bus.rom_ce !== 1'b1) begin errors++; $display("FAIL wrap_top got addr=%h ce=%b exp addr=fffffffc ce=1", bus.rom_addr, bus.rom_ce); end
    tick(); #1;
    checks++; if (bus.rom_addr !== 32'h0 || bus.if_pc !== 32'hFFFF_FFFC || bus.if_inst !== 32'hE0FF_FFFC) begin errors++; $display("FAIL wrap_step got addr=%h pc=%h inst=%h exp addr=0 pc=fffffffc inst=e0fffffc", bus.rom_addr, bus.if_pc, bus.if_inst); end
    tick(); #1;
    checks++; if (bus.if_pc !== 32'h0 || bus.if_inst !== 32'hE000_0000) begin errors++; $display("FAIL wrap_head got pc=%h inst=%h exp pc=0 inst=e0000000", bus.if_pc, bus.if_inst); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(); tick(); tick(); #1;
    checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", bus.if_valid); end
    rst = 1'b1;
    #1;
    checks++; if (bus.if_valid !== 1'b0 || bus.rom_ce !== 1'b0 || bus.if_pc !== 32'h0 || bus.if_inst !== 32'h0) begin errors++; $display("FAIL mid_async got v=%b ce=%b pc=%h inst=%h exp all 0", bus.if_valid, bus.rom_ce, bus.if_pc, bus.if_inst); end
    @(negedge clk);
    rst = 1'b0;
    bus.if_ready = 1'b1;
    tick(); #1;
    checks++; if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h0) begin errors++; $display("FAIL mid_restart got ce=%b addr=%h exp ce=1 addr=0", bus.rom_ce, bus.rom_addr); end
    tick(); #1;
    checks++; if (bus.if_pc !== 32'h0 || bus.if_valid !== 1'b1) begin errors++; $display("FAIL mid_head got pc=%h v=%b exp pc=0 v=1", bus.if_pc, bus.if_valid); end
  endtask

  task automatic test_misalign();
    do_reset();
    bus.if_ready = 1'b1;
    tick(); tick(); #1;
    checks++; if (bus.if_pc !== 32'h0 || bus.if_valid !== 1'b1) begin errors++; $display("FAIL mis_pre got pc=%h v=%b exp pc=0 v=1", bus.if_pc, bus.if_valid); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h102;
    tick();
    bus.redirect = 1'b0;
    #1;
`ifdef FETCH_MISALIGN_CHK_EN
    checks++; if (bus.rom_ce !== 1'b0 || bus.if_valid !== 1'b0 || bus.if_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag got ce=%b v=%b mis=%b exp ce=0 v=0 mis=1", bus.rom_ce, bus.if_valid, bus.if_misalign); end
    tick(); #1;
    checks++; if (bus.rom_ce !== 1'b0 || bus.if_misalign !== 1'b1) begin errors++; $display("FAIL mis_sticky got ce=%b mis=%b exp ce=0 mis=1", bus.rom_ce, bus.if_misalign); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++; if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h200 || bus.if_misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got ce=%b addr=%h mis=%b exp ce=1 addr=200 mis=0", bus.rom_ce, bus.rom_addr, bus.if_misalign); end
    tick(); #1;
    checks++; if (bus.if_pc !== 32'h200) begin errors++; $display("FAIL mis_resume got %h exp 200", bus.if_pc); end
`else
    checks++; if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h100 || bus.if_misalign !== 1'b0) begin errors++; $display("FAIL mis_ignore got ce=%b addr=%h mis=%b exp ce=1 addr=100 mis=0", bus.rom_ce, bus.rom_addr, bus.if_misalign); end
    tick(); #1;
    checks++; if (bus.if_pc !== 32'h100 || bus.if_inst !== 32'hE000_0100) begin errors++; $display("FAIL mis_ignore_head got pc=%h inst=%h exp pc=100 inst=e0000100", bus.if_pc, bus.if_inst); end
`endif
  endtask

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.if_ready    = 1'b0;
    test_reset();
    test_stream();
    test_stall_full();
    test_redirect();
    test_back_to_back();
    test_pc_wrap();
    test_reset_mid();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
